row_cache: RTL and testbench



---
 rtl/edge_pkg.sv | 20 ++
 rtl/line_delay.sv | 34 +++
 rtl/row_cache.sv | 137 +++++++++++++
 tb/tb_row_cache.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and frame-geometry helpers for the row cache feeding the edge-detection accelerator.
package edge_pkg;

  typedef enum logic [1:0] {IDLE, PREFILL, DRAIN, STREAM} rc_state_t;

  function automatic int row_width(input int width);
    return width / 4;
  endfunction

  function automatic int frame_words(input int width, input int height);
    return (width * height) / 4;
  endfunction

  localparam int DEF_WIDTH  = 352;
  localparam int DEF_HEIGHT = 288;
  localparam int ROW_WIDTH  = row_width(DEF_WIDTH);
  localparam int WORDS      = frame_words(DEF_WIDTH, DEF_HEIGHT);
  localparam int MAX_ADDR   = WORDS - 1;

endpackage

// File: rtl/line_delay.sv
// Fixed DEPTH-shift delay line built as a circular RAM; dout is the word pushed DEPTH shifts ago.
module line_delay #(
  parameter int DEPTH = 88,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  ram [DEPTH];
  logic [PW-1:0] ptr;

  // Read-before-write at the same pointer gives exactly DEPTH shifts of delay.
  assign dout = ram[ptr];

  always_ff @(posedge clk) begin
    if (shift) ram[ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (shift) begin
      if (ptr == PW'(DEPTH - 1)) ptr <= '0;
      else                       ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/row_cache.sv
// Fetches the frame word by word and presents three vertically aligned words (rows above,
// current, below) per accelerator read, with a fixed MEMORY_DELAY read latency.
module row_cache
  import edge_pkg::*;
#(
  parameter int WIDTH        = 352,
  parameter int HEIGHT       = 288,
  parameter int MEMORY_DELAY = 3,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              we,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       dataRa,
  output logic [31:0]       dataRb,
  output logic [31:0]       dataRc,
  output logic              row_cached
);

  localparam int ROW_WORDS   = row_width(WIDTH);
  localparam int FRAME_WORDS = frame_words(WIDTH, HEIGHT);
  localparam int LAST_ADDR   = FRAME_WORDS - 1;
  localparam int MEM_LAT     = MEMORY_DELAY - 1;
  localparam int CW          = $clog2(2 * ROW_WORDS + 1);

  rc_state_t         state, next_state;
  logic [ADDR_W:0]   fetch_addr;
  logic [CW-1:0]     arr_cnt;
  logic              filled;
  logic [MEM_LAT-1:0] vpipe;
  logic [MEM_LAT-1:0] zpipe;
  logic              req;
  logic              in_frame;
  logic              issue_any;
  logic              arrive;
  logic              shift;
  logic [31:0]       arr_word;
  logic [31:0]       l1_out;
  logic [31:0]       l2_out;

  assign req      = en && !we;
  assign in_frame = (fetch_addr <= (ADDR_W + 1)'(LAST_ADDR));
  assign arrive   = vpipe[MEM_LAT-1];
  assign arr_word = zpipe[MEM_LAT-1] ? 32'h0 : mem_rdata;
  assign shift    = arrive && (state != IDLE);

  // Out-of-frame issues still occupy a pipe slot so the zero word keeps the normal latency.
  assign mem_en   = issue_any && in_frame && !rst;
  assign mem_addr = mem_en ? fetch_addr[ADDR_W-1:0] : '0;

  always_comb begin
    next_state = state;
    issue_any  = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = PREFILL;
      end
      PREFILL: begin
        issue_any = 1'b1;
        if (fetch_addr == (ADDR_W + 1)'(ROW_WORDS - 1)) next_state = DRAIN;
      end
      DRAIN: begin
        if ((arrive && arr_cnt == CW'(ROW_WORDS - 1)) || (arr_cnt >= CW'(ROW_WORDS)))
          next_state = STREAM;
      end
      STREAM: begin
        issue_any = req && row_cached;
        if (!start) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row_cached <= 1'b0;
      fetch_addr <= '0;
      arr_cnt    <= '0;
      filled     <= 1'b0;
      vpipe      <= '0;
      zpipe      <= '0;
      dataRa     <= '0;
      dataRb     <= '0;
      dataRc     <= '0;
    end else begin
      state      <= next_state;
      row_cached <= (state == STREAM) && (next_state == STREAM);
      vpipe[0]   <= issue_any;
      zpipe[0]   <= !in_frame;
      for (int i = 1; i < MEM_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        zpipe[i] <= zpipe[i-1];
      end
      if (state == IDLE) begin
        fetch_addr <= '0;
        arr_cnt    <= '0;
        filled     <= 1'b0;
        vpipe      <= '0;
      end else begin
        if (issue_any && fetch_addr != '1) fetch_addr <= fetch_addr + (ADDR_W + 1)'(1);
        if (arrive) begin
          if (arr_cnt != CW'(2 * ROW_WORDS)) arr_cnt <= arr_cnt + CW'(1);
          if (arr_cnt == CW'(2 * ROW_WORDS - 1)) filled <= 1'b1;
        end
      end
      // The row above is only trustworthy once two full rows have passed through L1.
      if (arrive && state == STREAM) begin
        dataRc <= arr_word;
        dataRb <= l1_out;
        dataRa <= filled ? l2_out : 32'h0;
      end
    end
  end

  line_delay #(.DEPTH(ROW_WORDS), .W(32)) u_l1 (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .din   (arr_word),
    .dout  (l1_out)
  );

  line_delay #(.DEPTH(ROW_WORDS), .W(32)) u_l2 (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .din   (l1_out),
    .dout  (l2_out)
  );

endmodule

// File: tb/tb_row_cache.sv
// Directed bench for row_cache on a 16x4 frame; the memory model returns word k at address k.
module tb_row_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] dataRa, dataRb, dataRc;
  logic        row_cached;

  int n_checks = 0;
  int n_fail   = 0;

  logic        en_d1 = 1'b0, en_d2 = 1'b0;
  logic [15:0] a_d1 = '0, a_d2 = '0;

  always #5 clk = ~clk;

  row_cache #(.WIDTH(16), .HEIGHT(4), .MEMORY_DELAY(3), .ADDR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .en         (en),
    .we         (we),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .dataRa     (dataRa),
    .dataRb     (dataRb),
    .dataRc     (dataRc),
    .row_cached (row_cached)
  );

  // Two-cycle read memory; garbage when not enabled so unmasked zero slots show up.
  always @(posedge clk) begin
    en_d1 <= mem_en;
    a_d1  <= mem_addr;
    en_d2 <= en_d1;
    a_d2  <= a_d1;
  end
  assign mem_rdata = en_d2 ? {16'h0, a_d2} : 32'hDEAD_BEEF;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] expw(input int v);
    return (v >= 0 && v <= 15) ? 32'(v) : 32'h0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; en = 1'b1; we = 1'b0;
    next_cycle();
    next_cycle();
    n_checks++;
    if ({dataRa, dataRb, dataRc, row_cached, mem_en} !== 98'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got Ra=%0h Rb=%0h Rc=%0h rc=%0b me=%0b expected all 0",
               dataRa, dataRb, dataRc, row_cached, mem_en);
    end
    rst = 1'b0; en = 1'b0;
    next_cycle();
    n_checks++;
    if ({dataRa, dataRb, dataRc, row_cached, mem_en} !== 98'h0) begin
      n_fail++;
      $display("[TB] FAIL idle_outputs: got Ra=%0h Rb=%0h Rc=%0h rc=%0b me=%0b expected all 0",
               dataRa, dataRb, dataRc, row_cached, mem_en);
    end
  endtask

  task automatic test_prefill(input bit check_zero);
    for (int k = 0; k <= 8; k++) begin
      if (k == 0) begin start = 1'b1; en = 1'b1; we = 1'b0; end
      if (k == 8) en = 1'b0;
      #1;
      n_checks++;
      if (mem_en !== (k >= 1 && k <= 4)) begin
        n_fail++;
        $display("[TB] FAIL prefill_mem_en k=%0d: got %0b expected %0b", k, mem_en, (k >= 1 && k <= 4));
      end
      if (k >= 1 && k <= 4) begin
        n_checks++;
        if (mem_addr !== 16'(k - 1)) begin
          n_fail++;
          $display("[TB] FAIL prefill_addr k=%0d: got %0d expected %0d", k, mem_addr, k - 1);
        end
      end
      n_checks++;
      if (row_cached !== (k >= 8)) begin
        n_fail++;
        $display("[TB] FAIL prefill_row_cached k=%0d: got %0b expected %0b", k, row_cached, (k >= 8));
      end
      if (check_zero) begin
        n_checks++;
        if ({dataRa, dataRb, dataRc} !== 96'h0) begin
          n_fail++;
          $display("[TB] FAIL prefill_data k=%0d: got Ra=%0h Rb=%0h Rc=%0h expected 0", k, dataRa, dataRb, dataRc);
        end
      end
      if (k < 8) next_cycle();
    end
  endtask

  task automatic test_stream(input bit interleave);
    int due [48];
    int r = 0;
    int total;
    int a;
    bit rd;
    total = interleave ? 43 : 23;
    for (int i = 0; i < 48; i++) due[i] = -1;
    for (int j = 0; j < total; j++) begin
      rd = 1'b0;
      if (r < 20 && (!interleave || (j % 2) == 1)) begin
        en = 1'b1; we = 1'b0; rd = 1'b1;
        a = 4 + r;
        due[j + 3] = a;
        r++;
      end else if (r < 20) begin
        en = 1'b1; we = 1'b1;
      end else begin
        en = 1'b0; we = 1'b0;
      end
      #1;
      n_checks++;
      if (mem_en !== (rd && a <= 15)) begin
        n_fail++;
        $display("[TB] FAIL stream_mem_en j=%0d: got %0b expected %0b", j, mem_en, (rd && a <= 15));
      end
      if (rd && a <= 15) begin
        n_checks++;
        if (mem_addr !== 16'(a)) begin
          n_fail++;
          $display("[TB] FAIL stream_addr j=%0d: got %0d expected %0d", j, mem_addr, a);
        end
      end
      n_checks++;
      if (row_cached !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL stream_row_cached j=%0d: got %0b expected 1", j, row_cached);
      end
      if (due[j] >= 0) begin
        n_checks++;
        if (dataRc !== expw(due[j]) || dataRb !== expw(due[j] - 4) ||
            dataRa !== ((due[j] >= 8) ? expw(due[j] - 8) : 32'h0)) begin
          n_fail++;
          $display("[TB] FAIL stream_data addr=%0d: got Ra=%0h Rb=%0h Rc=%0h expected Ra=%0h Rb=%0h Rc=%0h",
                   due[j], dataRa, dataRb, dataRc,
                   ((due[j] >= 8) ? expw(due[j] - 8) : 32'h0), expw(due[j] - 4), expw(due[j]));
        end
      end
      next_cycle();
    end
    en = 1'b0; we = 1'b0;
  endtask

  task automatic test_restart();
    start = 1'b0; en = 1'b0;
    next_cycle();
    en = 1'b1; we = 1'b0;
    #1;
    n_checks++;
    if (row_cached !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL restart_idle: got rc=%0b me=%0b expected 0 0", row_cached, mem_en);
    end
    en = 1'b0;
    next_cycle();
    test_prefill(1'b0);
    test_stream(1'b1);
  endtask

  task automatic test_reset_mid_stream();
    start = 1'b0;
    next_cycle();
    next_cycle();
    test_prefill(1'b0);
    en = 1'b1; we = 1'b0;
    next_cycle();
    next_cycle();
    en = 1'b0; rst = 1'b1; start = 1'b0;
    next_cycle();
    rst = 1'b0; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if ({dataRa, dataRb, dataRc, row_cached, mem_en} !== 98'h0) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_stream k=%0d: got Ra=%0h Rb=%0h Rc=%0h rc=%0b me=%0b expected all 0",
                 k, dataRa, dataRb, dataRc, row_cached, mem_en);
      end
      next_cycle();
    end
    en = 1'b0;
    test_prefill(1'b1);
    test_stream(1'b0);
  endtask

  initial begin
    test_reset();
    test_prefill(1'b1);
    test_stream(1'b0);
    test_restart();
    test_reset_mid_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
